rf_wb_arbiter: RTL and testbench
================================

# rf_wb_arbiter

Write-back arbiter and load scoreboard for the 32 x 32-bit register file. It shares the file's single write port between the ALU write-back path and the load write-back path. It tracks registers with outstanding loads and reports read hazards to the decode stage. It sits between the execute/memory stages and the register file's WrEn_RF/WAddr_RF/WD_RF inputs.

## Interface
- DATA_W, 32, write data width
- ADDR_W, 5, register address width (32 registers, x0 hardwired zero)
- STARVE_MAX, 3, consecutive ALU denials before the ALU is forced to win
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- alu_valid / alu_ready  in / out  1  ALU write-back handshake
- alu_addr / alu_data  in  ADDR_W / DATA_W  ALU destination and result
- ld_valid / ld_ready  in / out  1  load write-back handshake
- ld_addr / ld_data  in  ADDR_W / DATA_W  load destination and data
- issue_ld_valid  in  1  a load is issued this cycle
- issue_ld_addr  in  ADDR_W  destination of the issued load
- raddr1, raddr2  in  ADDR_W  decode-stage source addresses
- hazard1, hazard2  out  1  source not yet readable, decode must stall
- WrEn_RF, WAddr_RF, WD_RF  out  1/ADDR_W/DATA_W  registered write port to the register file
- busy_vec  out  32  scoreboard contents (bit 0 always 0)

## Operation
- Transfer occurs when valid & ready on a port. Each ready is combinational and independent of that port's own valid.
- Arbitration:
  - Loads have priority by default.
  - Starve counter starve_cnt, width clog2(STARVE_MAX+1):
    - Increments (saturating at STARVE_MAX) each cycle alu_valid=1 and alu_ready=0.
    - Clears on an ALU transfer.
    - Holds otherwise.
  - force_alu = (starve_cnt == STARVE_MAX).
  - alu_ready = ~ld_valid | force_alu.
  - ld_ready = ~(alu_valid & force_alu).
- Write register: the winning transfer loads WAddr_RF/WD_RF and sets WrEn_RF=1 for exactly one cycle. With no transfer, WrEn_RF=0 and WAddr_RF/WD_RF hold.
- Address 0:
  - Transfers to x0 complete the handshake normally.
  - WrEn_RF stays 0.
  - The scoreboard is never set for x0.
- Scoreboard busy[31:1]:
  - Set on issue_ld_valid with issue_ld_addr != 0.
  - Cleared on a load transfer to ld_addr.
  - Same-cycle set and clear of the same address: set wins.
  - Issuing to an already-busy register keeps it busy; a bench assertion flags it as a protocol error.
  - ALU transfers never modify busy.
- Hazard: hazardN = (raddrN != 0) & (busy[raddrN] | (WrEn_RF & WAddr_RF == raddrN)). This covers the cycle in which a write is pending in the write register but not yet in the file.

## Timing
- Reset (asynchronous assert, synchronous release): WrEn_RF=0, WAddr_RF=0, WD_RF=0, busy_vec=0, starve_cnt=0.
- Reset mid-operation discards any pending write; WrEn_RF drops immediately.
- Ready/hazard outputs are combinational from current inputs and state; no input-to-output combinational path to WrEn_RF/WAddr_RF/WD_RF.
- Latency:
  - Transfer at edge N → WrEn_RF high during cycle N+1.
  - Register file captures at edge N+2.
  - Value readable from cycle N+2.
- Hazard on the loaded register:
  - Asserted from the cycle after issue.
  - Held through the cycle WrEn_RF is high.
  - Deasserted in cycle N+2.
- Worst-case ALU wait with continuous loads: STARVE_MAX cycles, then one forced grant.

## Structure
- Package rf_ctrl_pkg holds:
  - DATA_W, ADDR_W, STARVE_MAX defaults.
  - NUM_REGS=32.
  - typedef wb_req_t {addr, data}.
- Sub-module rf_scoreboard contains the busy vector, set/clear logic and both hazard lookups, including the pending-write term. The top contains arbitration, the starve counter and the write register.

## Test plan
- ALU alone: alu_valid, addr 5, data 0xDEADBEEF → alu_ready=1; WrEn_RF=1, WAddr_RF=5, WD_RF=0xDEADBEEF next cycle; one-cycle pulse.
- Collision: both valid, alu addr 3, ld addr 4, STARVE_MAX=3 → ld_ready=1, alu_ready=0 for 3 cycles under continuous loads, then alu_ready=1 and ld_ready=0; starve_cnt returns to 0.
- Scoreboard: issue load to x7, raddr1=7 → hazard1=1 until load write-back; hazard1 stays high the cycle WrEn_RF=1/WAddr_RF=7 and drops the cycle after.
- Same-cycle issue and write-back to x9 → busy[9] remains 1, hazard persists.
- x0: ALU write to addr 0 data 0x1234 → alu_ready=1, WrEn_RF stays 0; issue load to x0 → busy_vec stays 0, hazard1 with raddr1=0 stays 0.
- Reset during pending write: rst_n low while WrEn_RF=1 → WrEn_RF, busy_vec, starve_cnt zero immediately; normal operation resumes after release.

Source files
------------

// File: rtl/rf_ctrl_pkg.sv
// Shared constants and types for the register-file write-back control path.
package rf_ctrl_pkg;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 5;
  localparam int STARVE_MAX = 3;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Load scoreboard: tracks registers with outstanding loads and reports decode read hazards,
// including the write still sitting in the write register.
module rf_scoreboard #(
  parameter int ADDR_W   = rf_ctrl_pkg::ADDR_W,
  parameter int NUM_REGS = rf_ctrl_pkg::NUM_REGS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                set_valid_i,
  input  logic [ADDR_W-1:0]   set_addr_i,
  input  logic                clr_valid_i,
  input  logic [ADDR_W-1:0]   clr_addr_i,
  input  logic                pend_valid_i,
  input  logic [ADDR_W-1:0]   pend_addr_i,
  input  logic [ADDR_W-1:0]   raddr1_i,
  input  logic [ADDR_W-1:0]   raddr2_i,
  output logic                hazard1_o,
  output logic                hazard2_o,
  output logic [NUM_REGS-1:0] busy_vec_o
);

  logic [NUM_REGS-1:0] busy_q, busy_d;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    busy_d = busy_q;
    if (clr_valid_i) busy_d[clr_addr_i] = 1'b0;
    // Applied after the clear so a same-cycle re-issue keeps the register busy.
    if (set_valid_i) busy_d[set_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state uses non-blocking assignments; the small busy vector is reset, unlike a RAM array.
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign hazard1_o = (raddr1_i != '0) &
                     (busy_q[raddr1_i] | (pend_valid_i & (pend_addr_i == raddr1_i)));
  assign hazard2_o = (raddr2_i != '0) &
                     (busy_q[raddr2_i] | (pend_valid_i & (pend_addr_i == raddr2_i)));
  assign busy_vec_o = busy_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register file write port between ALU and load write-back, with load priority
// and a starvation counter that eventually forces an ALU grant.
module rf_wb_arbiter #(
  parameter int DATA_W     = rf_ctrl_pkg::DATA_W,
  parameter int ADDR_W     = rf_ctrl_pkg::ADDR_W,
  parameter int STARVE_MAX = rf_ctrl_pkg::STARVE_MAX
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              issue_ld_valid,
  input  logic [ADDR_W-1:0] issue_ld_addr,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic              hazard1,
  output logic              hazard2,
  output logic              WrEn_RF,
  output logic [ADDR_W-1:0] WAddr_RF,
  output logic [DATA_W-1:0] WD_RF,
  output logic [31:0]       busy_vec
);

  import rf_ctrl_pkg::*;

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             force_alu;
  logic             alu_xfer, ld_xfer;
  wb_req_t          wr_q, wr_d;
  logic             wr_en_q, wr_en_d;

  assign force_alu = (starve_cnt_q == CNT_W'(STARVE_MAX));
  assign alu_ready = ~ld_valid | force_alu;
  assign ld_ready  = ~(alu_valid & force_alu);
  assign alu_xfer  = alu_valid & alu_ready;
  assign ld_xfer   = ld_valid & ld_ready;

  // The ready equations make the two transfers mutually exclusive.
  always_comb begin
    wr_d         = wr_q;
    wr_en_d      = 1'b0;
    starve_cnt_d = starve_cnt_q;
    if (ld_xfer) begin
      wr_d    = '{addr: ld_addr, data: ld_data};
      wr_en_d = (ld_addr != '0);
    end else if (alu_xfer) begin
      wr_d    = '{addr: alu_addr, data: alu_data};
      wr_en_d = (alu_addr != '0);
    end
    if (alu_xfer)
      starve_cnt_d = '0;
    else if (alu_valid && !force_alu)
      starve_cnt_d = starve_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q         <= '0;
      wr_en_q      <= 1'b0;
      starve_cnt_q <= '0;
    end else begin
      wr_q         <= wr_d;
      wr_en_q      <= wr_en_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign WrEn_RF  = wr_en_q;
  assign WAddr_RF = wr_q.addr;
  assign WD_RF    = wr_q.data;

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .set_valid_i  (issue_ld_valid),
    .set_addr_i   (issue_ld_addr),
    .clr_valid_i  (ld_xfer),
    .clr_addr_i   (ld_addr),
    .pend_valid_i (wr_en_q),
    .pend_addr_i  (wr_q.addr),
    .raddr1_i     (raddr1),
    .raddr2_i     (raddr2),
    .hazard1_o    (hazard1),
    .hazard2_o    (hazard2),
    .busy_vec_o   (busy_vec)
  );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed vector table, corner-case sequences
// and randomized traffic against a behavioural model.
module tb_rf_wb_arbiter;

  localparam int SMAX = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, ld_valid, issue_ld_valid;
  logic [4:0]  alu_addr, ld_addr, issue_ld_addr, raddr1, raddr2;
  logic [31:0] alu_data, ld_data;
  logic        alu_ready, ld_ready, hazard1, hazard2, WrEn_RF;
  logic [4:0]  WAddr_RF;
  logic [31:0] WD_RF, busy_vec;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  int          m_starve;
  bit          m_busy [32];
  bit          m_wr_en;
  logic [4:0]  m_waddr;
  logic [31:0] m_wd;

  typedef struct {
    bit          av;
    logic [4:0]  aa;
    logic [31:0] ad;
    bit          lv;
    logic [4:0]  la;
    logic [31:0] ld;
    bit          exp_ar;
    bit          exp_lr;
    bit          exp_wren;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t vecs [9];

  always #5 clk = ~clk;

  rf_wb_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .alu_valid      (alu_valid),
    .alu_ready      (alu_ready),
    .alu_addr       (alu_addr),
    .alu_data       (alu_data),
    .ld_valid       (ld_valid),
    .ld_ready       (ld_ready),
    .ld_addr        (ld_addr),
    .ld_data        (ld_data),
    .issue_ld_valid (issue_ld_valid),
    .issue_ld_addr  (issue_ld_addr),
    .raddr1         (raddr1),
    .raddr2         (raddr2),
    .hazard1        (hazard1),
    .hazard2        (hazard2),
    .WrEn_RF        (WrEn_RF),
    .WAddr_RF       (WAddr_RF),
    .WD_RF          (WD_RF),
    .busy_vec       (busy_vec)
  );

  // Issuing to a register that is still busy (and not being written back now) is a protocol error.
  always @(posedge clk) begin
    if (rst_n && issue_ld_valid && issue_ld_addr != 5'd0)
      assert (!(busy_vec[issue_ld_addr] && !(ld_valid && ld_ready && ld_addr == issue_ld_addr)))
        else $error("protocol error: load issued to busy register x%0d", issue_ld_addr);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_starve = 0;
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_wr_en = 1'b0;
    m_waddr = '0;
    m_wd    = '0;
  endtask

  function automatic bit m_alu_ready();
    return !ld_valid || (m_starve >= SMAX);
  endfunction

  function automatic bit m_ld_ready();
    return !(alu_valid && m_starve >= SMAX);
  endfunction

  function automatic bit m_hazard(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    return m_busy[r] || (m_wr_en && m_waddr == r);
  endfunction

  function automatic logic [31:0] m_busy_word();
    logic [31:0] w;
    for (int i = 0; i < 32; i++) w[i] = m_busy[i];
    return w;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    bit ar, lr, ax, lx;
    ar = m_alu_ready();
    lr = m_ld_ready();
    ax = alu_valid && ar;
    lx = ld_valid && lr;
    if (lx) begin
      m_wr_en = (ld_addr != 0); m_waddr = ld_addr; m_wd = ld_data;
    end else if (ax) begin
      m_wr_en = (alu_addr != 0); m_waddr = alu_addr; m_wd = alu_data;
    end else begin
      m_wr_en = 1'b0;
    end
    if (ax) m_starve = 0;
    else if (alu_valid && !ar) m_starve = (m_starve + 1 > SMAX) ? SMAX : m_starve + 1;
    if (lx) m_busy[ld_addr] = 1'b0;
    if (issue_ld_valid && issue_ld_addr != 0) m_busy[issue_ld_addr] = 1'b1;
  endtask

  // Compare everything against the model mid-cycle, then take one clock edge.
  task automatic tick();
    #2;
    check("alu_ready", alu_ready, m_alu_ready());
    check("ld_ready",  ld_ready,  m_ld_ready());
    check("hazard1",   hazard1,   m_hazard(raddr1));
    check("hazard2",   hazard2,   m_hazard(raddr2));
    check("WrEn_RF",   WrEn_RF,   m_wr_en);
    check("busy_vec",  busy_vec,  m_busy_word());
    if (m_wr_en) begin
      check("WAddr_RF", WAddr_RF, m_waddr);
      check("WD_RF",    WD_RF,    m_wd);
    end
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_addr = 0; alu_data = 0;
    ld_valid = 0;  ld_addr = 0;  ld_data = 0;
    issue_ld_valid = 0; issue_ld_addr = 0;
    raddr1 = 0; raddr2 = 0;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_WrEn",  WrEn_RF,  0);
    check("reset_WAddr", WAddr_RF, 0);
    check("reset_WD",    WD_RF,    0);
    check("reset_busy",  busy_vec, 0);
    rst_n = 1'b1;

    // av aa ad | lv la ld | exp_ar exp_lr | exp_wren exp_waddr exp_wd
    vecs[0] = '{1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0,  1, 1, 1, 5'd5, 32'hDEADBEEF};
    vecs[1] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  1, 1, 0, 5'd0, 32'h0};
    vecs[2] = '{1, 5'd3, 32'h33,       1, 5'd4, 32'h44, 0, 1, 1, 5'd4, 32'h44};
    vecs[3] = '{1, 5'd3, 32'h33,       1, 5'd4, 32'h44, 0, 1, 1, 5'd4, 32'h44};
    vecs[4] = '{1, 5'd3, 32'h33,       1, 5'd4, 32'h44, 0, 1, 1, 5'd4, 32'h44};
    vecs[5] = '{1, 5'd3, 32'h33,       1, 5'd4, 32'h44, 1, 0, 1, 5'd3, 32'h33};
    vecs[6] = '{1, 5'd3, 32'h33,       1, 5'd4, 32'h44, 0, 1, 1, 5'd4, 32'h44};
    vecs[7] = '{0, 5'd0, 32'h0,        1, 5'd0, 32'h55, 0, 1, 0, 5'd0, 32'h0};
    vecs[8] = '{1, 5'd0, 32'h1234,     0, 5'd0, 32'h0,  1, 1, 0, 5'd0, 32'h0};

    for (int i = 0; i < 9; i++) begin
      alu_valid = vecs[i].av; alu_addr = vecs[i].aa; alu_data = vecs[i].ad;
      ld_valid  = vecs[i].lv; ld_addr  = vecs[i].la; ld_data  = vecs[i].ld;
      #2;
      check($sformatf("vec%0d_alu_ready", i), alu_ready, vecs[i].exp_ar);
      check($sformatf("vec%0d_ld_ready", i),  ld_ready,  vecs[i].exp_lr);
      tick();
      idle_inputs();
      #2;
      check($sformatf("vec%0d_WrEn", i), WrEn_RF, vecs[i].exp_wren);
      if (vecs[i].exp_wren) begin
        check($sformatf("vec%0d_WAddr", i), WAddr_RF, vecs[i].exp_waddr);
        check($sformatf("vec%0d_WD", i),    WD_RF,    vecs[i].exp_wd);
      end
    end
    tick();

    // Scoreboard on x7: hazard from the cycle after issue until the cycle after WrEn_RF
    issue_ld_valid = 1; issue_ld_addr = 7; raddr1 = 7;
    #2; check("x7_hazard_at_issue", hazard1, 0);
    tick();
    issue_ld_valid = 0;
    #2; check("x7_hazard_after_issue", hazard1, 1);
    tick();
    tick();
    ld_valid = 1; ld_addr = 7; ld_data = 32'h77;
    #2; check("x7_hazard_at_wb", hazard1, 1);
    tick();
    ld_valid = 0;
    #2;
    check("x7_wren", WrEn_RF, 1);
    check("x7_waddr", WAddr_RF, 7);
    check("x7_hazard_pending", hazard1, 1);
    tick();
    #2;
    check("x7_hazard_cleared", hazard1, 0);
    check("x7_wren_pulse", WrEn_RF, 0);
    tick();

    // Same-cycle issue and write-back to x9: set wins
    issue_ld_valid = 1; issue_ld_addr = 9;
    tick();
    ld_valid = 1; ld_addr = 9; ld_data = 32'h99; raddr2 = 9;
    tick();
    idle_inputs(); raddr2 = 9;
    #2;
    check("x9_busy_kept", busy_vec[9], 1);
    check("x9_hazard2", hazard2, 1);
    tick();
    tick();
    check("x9_hazard_persists", hazard2, 1);
    ld_valid = 1; ld_addr = 9; ld_data = 32'h9A;
    tick();
    ld_valid = 0;
    tick();
    tick();

    // x0 load issue never marks the scoreboard
    issue_ld_valid = 1; issue_ld_addr = 0; raddr1 = 0;
    tick();
    issue_ld_valid = 0;
    #2;
    check("x0_busy_clear", busy_vec, 0);
    check("x0_hazard1", hazard1, 0);
    tick();

    // Reset while a write is pending and the starve counter is non-zero
    issue_ld_valid = 1; issue_ld_addr = 12;
    tick();
    issue_ld_valid = 0;
    alu_valid = 1; alu_addr = 3; alu_data = 32'h33;
    ld_valid = 1;  ld_addr = 4;  ld_data = 32'h44;
    tick();
    tick();
    check("rst_pre_wren", WrEn_RF, 1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_wren_drop", WrEn_RF, 0);
    check("rst_busy_zero", busy_vec, 0);
    check("rst_waddr_zero", WAddr_RF, 0);
    @(posedge clk); @(posedge clk);
    #1;
    rst_n = 1'b1;
    // Starve counter must restart from zero: three denials before the forced grant
    for (int i = 0; i < 4; i++) begin
      #2;
      check($sformatf("rst_resume_alu_ready%0d", i), alu_ready, (i == 3));
      check($sformatf("rst_resume_ld_ready%0d", i),  ld_ready,  (i != 3));
      tick();
    end
    idle_inputs();
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [4:0] ia;
      alu_valid = ($urandom_range(0, 3) != 0);
      alu_addr  = 5'($urandom_range(0, 31));
      alu_data  = $urandom;
      ld_valid  = ($urandom_range(0, 2) != 0);
      ld_addr   = 5'($urandom_range(0, 31));
      ld_data   = $urandom;
      ia        = 5'($urandom_range(0, 31));
      issue_ld_valid = ($urandom_range(0, 1) == 1) && !m_busy[ia];
      issue_ld_addr  = ia;
      raddr1 = 5'($urandom_range(0, 31));
      raddr2 = 5'($urandom_range(0, 31));
      tick();
    end
    idle_inputs();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
